// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter: core fetch (32-bit word reads) vs I2C programming port (byte r/w).
// Optional IMEM_ARB_LOCK_EN adds i_prog_lock, which holds off fetch while programming.
module imem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic              o_fetch_gnt,
  output logic              o_fetch_valid,
  output logic [31:0]       o_fetch_data,
  input  logic              i_prog_req,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [7:0]        i_prog_wdata,
`ifdef IMEM_ARB_LOCK_EN
  input  logic              i_prog_lock,
`endif
  output logic              o_prog_gnt,
  output logic              o_prog_valid,
  output logic [7:0]        o_prog_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_mem_we,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_busy,
  output logic              o_owner
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              first_q;
  logic [LW-1:0]     lat_q;
  logic [SW-1:0]     starve_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              we_q;
  logic              owner_q;
  logic [31:0]       fetch_data_q;
  logic [7:0]        prog_rdata_q;
  logic              lock;
  logic              fetch_ok;
  logic              prog_win;
  logic              fetch_win;

`ifdef IMEM_ARB_LOCK_EN
  assign lock = i_prog_lock;
`else
  assign lock = 1'b0;
`endif

  assign fetch_ok  = i_fetch_req & ~lock;
  assign prog_win  = i_prog_req & ~(fetch_ok & (starve_q == SW'(STARVE_MAX)));
  assign fetch_win = fetch_ok & ~prog_win;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (prog_win || fetch_win) state_d = ACCESS;
      ACCESS:  if (lat_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      first_q      <= 1'b0;
      lat_q        <= '0;
      starve_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      fetch_data_q <= '0;
      prog_rdata_q <= '0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (prog_win || fetch_win) begin
            owner_q <= prog_win;
            addr_q  <= prog_win ? i_prog_addr : i_fetch_addr;
            we_q    <= prog_win & i_prog_we;
            lat_q   <= LW'(MEM_LAT - 1);
            first_q <= 1'b1;
            if (prog_win) wdata_q <= i_prog_wdata;
          end
        end
        ACCESS: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - LW'(1);
          end else if (owner_q) begin
            prog_rdata_q <= we_q ? 8'h00 : i_mem_rdata[7:0];
          end else begin
            fetch_data_q <= i_mem_rdata;
          end
        end
        default: ;
      endcase

      // Fetch not asking (or locked out) means nothing is starving.
      if (lock) begin
        starve_q <= '0;
      end else if (state_q == IDLE) begin
        if (!i_fetch_req || fetch_win)
          starve_q <= '0;
        else if (prog_win && starve_q != SW'(STARVE_MAX))
          starve_q <= starve_q + SW'(1);
      end
    end
  end

  // Strobes decode from the async-reset state so they drop the moment reset asserts.
  assign o_fetch_gnt   = (state_q == ACCESS) & first_q & ~owner_q;
  assign o_prog_gnt    = (state_q == ACCESS) & first_q & owner_q;
  assign o_mem_we      = (state_q == ACCESS) & first_q & owner_q & we_q;
  assign o_fetch_valid = (state_q == DONE) & ~owner_q;
  assign o_prog_valid  = (state_q == DONE) & owner_q;
  assign o_busy        = (state_q != IDLE);
  assign o_owner       = owner_q;
  assign o_mem_addr    = owner_q ? addr_q : {addr_q[ADDR_W-1:2], 2'b00};
  assign o_mem_wdata   = wdata_q;
  assign o_fetch_data  = fetch_data_q;
  assign o_prog_rdata  = prog_rdata_q;

endmodule
